// File: rtl/multi_box_bouncer.sv
// Animates N_BOXES bouncing boxes; one box state update per cycle during vblank.
// Pixel colour is composited with lowest-index priority and registered.
module multi_box_bouncer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int N_BOXES       = 4,
    parameter int BOX_WIDTH     = 64,
    parameter int BOX_HEIGHT    = 48,
    parameter int VEL_W         = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_tick,
    input  logic                             pause,
    input  logic                             visible,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  position_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] position_y,
    output logic [3:0]                       r,
    output logic [3:0]                       g,
    output logic [3:0]                       b,
    output logic                             busy,
    output logic [15:0]                      bounce_count
);

    localparam int XW    = $clog2(SCREEN_WIDTH);
    localparam int YW    = $clog2(SCREEN_HEIGHT);
    localparam int IW    = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
    localparam int MAX_X = SCREEN_WIDTH - BOX_WIDTH;
    localparam int MAX_Y = SCREEN_HEIGHT - BOX_HEIGHT;

    localparam logic [IW-1:0]          LAST   = IW'(N_BOXES - 1);
    localparam logic signed [XW+1:0]   MAXX_S = (XW+2)'(MAX_X);
    localparam logic signed [YW+1:0]   MAXY_S = (YW+2)'(MAX_Y);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [XW-1:0]            x   [N_BOXES];
    logic [YW-1:0]            y   [N_BOXES];
    logic signed [VEL_W-1:0]  vx  [N_BOXES];
    logic signed [VEL_W-1:0]  vy  [N_BOXES];
    logic [2:0]               col [N_BOXES];

    function automatic logic [XW-1:0] x_init(int i);
        return XW'((16 + 97 * i) % MAX_X);
    endfunction

    function automatic logic [YW-1:0] y_init(int i);
        return YW'((16 + 61 * i) % MAX_Y);
    endfunction

    function automatic logic signed [VEL_W-1:0] vx_init(int i);
        int m;
        m = (i % 3) + 1;
        return (i % 2 == 0) ? VEL_W'(m) : VEL_W'(-m);
    endfunction

    function automatic logic signed [VEL_W-1:0] vy_init(int i);
        return (i % 2 == 0) ? VEL_W'(1) : VEL_W'(-1);
    endfunction

    function automatic logic [2:0] col_init(int i);
        return 3'((i % 7) + 1);
    endfunction

    logic signed [XW+1:0]    tx;
    logic signed [YW+1:0]    ty;
    logic [XW-1:0]           nx;
    logic [YW-1:0]           ny;
    logic signed [VEL_W-1:0] nvx;
    logic signed [VEL_W-1:0] nvy;
    logic                    hx;
    logic                    hy;
    logic [2:0]              ncol;
    logic [15:0]             bump;

    // Next state of the box selected by idx; a wall hit clamps and reflects.
    always_comb begin
        tx   = $signed({2'b00, x[idx]}) + (XW+2)'(vx[idx]);
        ty   = $signed({2'b00, y[idx]}) + (YW+2)'(vy[idx]);
        nx   = tx[XW-1:0];
        ny   = ty[YW-1:0];
        nvx  = vx[idx];
        nvy  = vy[idx];
        hx   = 1'b0;
        hy   = 1'b0;
        if (tx[XW+1]) begin
            nx  = '0;
            nvx = -vx[idx];
            hx  = 1'b1;
        end else if (tx > MAXX_S) begin
            nx  = XW'(MAX_X);
            nvx = -vx[idx];
            hx  = 1'b1;
        end
        if (ty[YW+1]) begin
            ny  = '0;
            nvy = -vy[idx];
            hy  = 1'b1;
        end else if (ty > MAXY_S) begin
            ny  = YW'(MAX_Y);
            nvy = -vy[idx];
            hy  = 1'b1;
        end
        ncol = col[idx];
        if (hx | hy)
            ncol = (col[idx] == 3'd7) ? 3'd1 : col[idx] + 3'd1;
    end

    assign bump = {15'b0, hx} + {15'b0, hy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            bounce_count <= '0;
            for (int i = 0; i < N_BOXES; i++) begin
                x[i]   <= x_init(i);
                y[i]   <= y_init(i);
                vx[i]  <= vx_init(i);
                vy[i]  <= vy_init(i);
                col[i] <= col_init(i);
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_tick && !pause) begin
                        state <= UPDATE;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    x[idx]       <= nx;
                    y[idx]       <= ny;
                    vx[idx]      <= nvx;
                    vy[idx]      <= nvy;
                    col[idx]     <= ncol;
                    bounce_count <= bounce_count + bump;
                    if (idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic       hit;
    logic [2:0] pcol;

    // Scan from the highest index down so the lowest overlapping box wins.
    always_comb begin
        hit  = 1'b0;
        pcol = '0;
        for (int i = N_BOXES - 1; i >= 0; i--) begin
            if ({1'b0, position_x} >= {1'b0, x[i]} &&
                {1'b0, position_x} <  {1'b0, x[i]} + (XW+1)'(BOX_WIDTH) &&
                {1'b0, position_y} >= {1'b0, y[i]} &&
                {1'b0, position_y} <  {1'b0, y[i]} + (YW+1)'(BOX_HEIGHT)) begin
                hit  = 1'b1;
                pcol = col[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (!visible) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (hit) begin
            r <= {4{pcol[0]}};
            g <= {4{pcol[1]}};
            b <= {4{pcol[2]}};
        end else begin
            r <= 4'h1;
            g <= 4'h1;
            b <= 4'h1;
        end
    end

endmodule

// File: tb/tb_multi_box_bouncer.sv
// Bench for multi_box_bouncer: default 4-box instance plus a tiny 1-box
// screen where the box bounces corner to corner every 33 frames.
module tb_multi_box_bouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       pause;
    logic       visible;
    logic [9:0] px;
    logic [8:0] py;

    logic [3:0]  r0, g0, b0, r1, g1, b1;
    logic        busy0, busy1;
    logic [15:0] bc0, bc1;

    always #5 clk = ~clk;

    multi_box_bouncer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .pause        (pause),
        .visible      (visible),
        .position_x   (px),
        .position_y   (py),
        .r            (r0),
        .g            (g0),
        .b            (b0),
        .busy         (busy0),
        .bounce_count (bc0)
    );

    multi_box_bouncer #(
        .SCREEN_WIDTH  (96),
        .SCREEN_HEIGHT (80),
        .N_BOXES       (1),
        .BOX_WIDTH     (64),
        .BOX_HEIGHT    (48),
        .VEL_W         (4)
    ) u_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .pause        (pause),
        .visible      (visible),
        .position_x   (px[6:0]),
        .position_y   (py[6:0]),
        .r            (r1),
        .g            (g1),
        .b            (b1),
        .busy         (busy1),
        .bounce_count (bc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: k=0 is the 4-box 640x480 screen, k=1 the 1-box 96x80 one.
    int mx [2][8];
    int my [2][8];
    int mvx [2][8];
    int mvy [2][8];
    int mcol [2][8];
    int mbc [2];
    int mf, sf;

    function automatic int nb(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int lim_x(int k);
        return (k == 0) ? 576 : 32;
    endfunction

    function automatic int lim_y(int k);
        return (k == 0) ? 432 : 32;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mbc[k] = 0;
            for (int i = 0; i < nb(k); i++) begin
                mx[k][i]   = (16 + 97 * i) % lim_x(k);
                my[k][i]   = (16 + 61 * i) % lim_y(k);
                mvx[k][i]  = (i % 2 == 0) ? (i % 3 + 1) : -(i % 3 + 1);
                mvy[k][i]  = (i % 2 == 0) ? 1 : -1;
                mcol[k][i] = (i % 7) + 1;
            end
        end
    endtask

    task automatic model_frame(int k);
        int t, h;
        for (int i = 0; i < nb(k); i++) begin
            h = 0;
            t = mx[k][i] + mvx[k][i];
            if (t < 0 || t > lim_x(k)) begin
                mx[k][i] = (t < 0) ? 0 : lim_x(k);
                mvx[k][i] = -mvx[k][i];
                h++;
            end else mx[k][i] = t;
            t = my[k][i] + mvy[k][i];
            if (t < 0 || t > lim_y(k)) begin
                my[k][i] = (t < 0) ? 0 : lim_y(k);
                mvy[k][i] = -mvy[k][i];
                h++;
            end else my[k][i] = t;
            if (h > 0) mcol[k][i] = (mcol[k][i] == 7) ? 1 : mcol[k][i] + 1;
            mbc[k] = (mbc[k] + h) % 65536;
        end
    endtask

    function automatic logic [11:0] model_rgb(int k, int xx, int yy, bit v);
        logic [2:0] c;
        if (!v) return 12'h000;
        for (int i = 0; i < nb(k); i++) begin
            if (xx >= mx[k][i] && xx < mx[k][i] + 64 &&
                yy >= my[k][i] && yy < my[k][i] + 48) begin
                c = 3'(mcol[k][i]);
                return {{4{c[0]}}, {4{c[1]}}, {4{c[2]}}};
            end
        end
        return 12'h111;
    endfunction

    // Continuous pixel compare: expectation captured at the edge, checked half a cycle later.
    logic        chk_on = 1'b0;
    logic        ev = 1'b0;
    logic [11:0] e0, e1;

    always @(posedge clk) begin
        ev <= chk_on && rst_n;
        e0 <= model_rgb(0, int'(px), int'(py), visible);
        e1 <= model_rgb(1, int'(px[6:0]), int'(py[6:0]), visible);
    end

    always @(negedge clk) begin
        if (ev) begin
            chk("rgb_main", {r0, g0, b0}, e0);
            chk("rgb_small", {r1, g1, b1}, e1);
        end
    end

    task automatic drive(int xx, int yy, bit v);
        @(negedge clk);
        px = 10'(xx);
        py = 9'(yy);
        visible = v;
    endtask

    task automatic lit(string nm, int k, int xx, int yy, bit v, logic [11:0] exp);
        drive(xx, yy, v);
        @(negedge clk);
        chk(nm, (k == 0) ? {r0, g0, b0} : {r1, g1, b1}, exp);
    endtask

    task automatic probe(int xx, int yy);
        if (xx < 0 || yy < 0 || xx > 1023 || yy > 511) return;
        drive(xx, yy, 1'b1);
    endtask

    task automatic probe_all();
        int bx, by;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < nb(k); i++) begin
                bx = mx[k][i];
                by = my[k][i];
                probe(bx, by);
                probe(bx - 1, by);
                probe(bx, by - 1);
                probe(bx + 63, by + 47);
                probe(bx + 64, by + 47);
                probe(bx + 63, by + 48);
            end
        end
        drive(5, 5, 1'b0);
        probe(639, 479);
    endtask

    task automatic do_tick(bit extra);
        int  c0, c1;
        bit  acc;
        @(negedge clk);
        chk_on = 1'b0;
        visible = 1'b0;
        @(negedge clk);
        acc = !pause;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int n = 1; n <= 12; n++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            frame_tick = (extra && n == 2);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        chk("busy_main_cycles", c0, acc ? 4 : 0);
        chk("busy_small_cycles", c1, acc ? (extra ? 2 : 1) : 0);
        if (acc) begin
            model_frame(0);
            model_frame(1);
            mf++;
            sf++;
            if (extra) begin
                model_frame(1);
                sf++;
            end
        end
        chk("bounce_main", bc0, mbc[0]);
        chk("bounce_small", bc1, mbc[1]);
        chk_on = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_tick = 1'b0;
        pause = 1'b0;
        visible = 1'b0;
        px = '0;
        py = '0;
        mf = 0;
        sf = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rgb", {r0, g0, b0}, 12'h000);
        chk("reset_busy", busy0, 0);
        chk("reset_bounce", bc0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;

        lit("box0_reset", 0, 20, 20, 1'b1, 12'hF00);
        lit("bg_reset", 0, 0, 0, 1'b1, 12'h111);
        lit("blank", 0, 20, 20, 1'b0, 12'h000);
        lit("box1_reset", 0, 113, 77, 1'b1, 12'h0F0);
        lit("small_reset", 1, 20, 20, 1'b1, 12'hF00);
        probe_all();

        // First frame, with a second tick on update cycle 2 that must be dropped.
        do_tick(1'b1);
        lit("box0_f1_in", 0, 17, 17, 1'b1, 12'hF00);
        lit("box0_f1_out", 0, 16, 20, 1'b1, 12'h111);
        lit("box1_f1_in", 0, 111, 76, 1'b1, 12'h0F0);
        lit("box1_f1_out", 0, 110, 76, 1'b1, 12'h111);
        probe_all();

        while (mf < 214) begin
            do_tick(1'b0);
            probe_all();
            if (mf == 56) chk("bounce_f56", bc0, 0);
            if (mf == 57) begin
                chk("bounce_f57", bc0, 1);
                lit("box1_after_hit", 0, 0, 20, 1'b1, 12'hFF0);
            end
            if (sf == 50) begin
                chk("corner_bounce", bc1, 4);
                lit("corner_col", 1, 0, 0, 1'b1, 12'hFF0);
            end
            if (sf == 215) begin
                chk("col_wrap_bounce", bc1, 14);
                lit("col_wrap_in", 1, 32, 32, 1'b1, 12'hF00);
                lit("col_wrap_out", 1, 31, 31, 1'b1, 12'h111);
            end
        end

        pause = 1'b1;
        repeat (3) begin
            do_tick(1'b0);
            probe_all();
        end
        pause = 1'b0;

        // Reset asserted while the main instance is mid-update.
        @(negedge clk);
        chk_on = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_main", busy0, 0);
        chk("rst_busy_small", busy1, 0);
        chk("rst_rgb", {r0, g0, b0}, 12'h000);
        chk("rst_bounce", bc0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_rst", busy0, 0);
        end
        chk_on = 1'b1;
        lit("box0_rst2", 0, 16, 16, 1'b1, 12'hF00);
        lit("box1_rst2", 0, 113, 77, 1'b1, 12'h0F0);
        probe_all();
        do_tick(1'b0);
        lit("box0_rst2_f1", 0, 17, 17, 1'b1, 12'hF00);
        probe_all();

        @(negedge clk);
        chk_on = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
